// File: rtl/bcd_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Number of decimal digits needed to show the largest w-bit unsigned value.
  function automatic int unsigned min_digits(int unsigned w);
    longint unsigned v;
    int unsigned     d;
    v = (64'd1 << w) - 64'd1;
    d = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 64'd0) begin
        d++;
        v = v / 64'd10;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_adj3.sv
// Shift-and-add-3 correction cell: a nibble of 5 or more gets 3 added before the shift.
module bcd_adj3 (
  input  logic [3:0] in_i,
  output logic [3:0] out_o
);

  assign out_o = (in_i >= 4'd5) ? in_i + 4'd3 : in_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one shift-and-add-3 step per clock, registered result.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned W      = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [W-1:0]          bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned RegW = BcdW + W;
  localparam int unsigned CntW = $clog2(W + 1);

  if (W < 4 || W > 32) begin : g_w_chk
    $error("bin2bcd_seq: W must be within 4..32");
  end
  if (DIGITS < min_digits(W)) begin : g_digits_chk
    $error("bin2bcd_seq: DIGITS too small to hold the largest W-bit value");
  end

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RegW-1:0]   work_q, work_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [RegW-1:0]   work_adj;
  logic [RegW-1:0]   work_shl;
  logic              unused_adj_msb;

  // Binary field passes straight through; every BCD nibble gets its own correction cell.
  assign work_adj[W-1:0] = work_q[W-1:0];
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_adj3 u_adj (
      .in_i  (work_q[W+4*i +: 4]),
      .out_o (work_adj[W+4*i +: 4])
    );
  end

  // With enough digits the top bit is always zero before the shift drops it.
  assign work_shl       = {work_adj[RegW-2:0], 1'b0};
  assign unused_adj_msb = work_adj[RegW-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          work_d  = {{BcdW{1'b0}}, bin_i};
          cnt_d   = CntW'(W);
          state_d = StShift;
        end
      end
      StShift: begin
        work_d = work_shl;
        cnt_d  = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          bcd_d   = work_shl[RegW-1 -: BcdW];
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      work_q  <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = (state_q == StDone);
  assign bcd_o  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: arithmetic reference model plus directed literal checks.
module tb_bin2bcd_seq;

  localparam int unsigned W      = 16;
  localparam int unsigned DIGITS = 5;
  localparam int unsigned BW     = 4 * DIGITS;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  bin;
  logic          busy;
  logic          done;
  logic [BW-1:0] bcd;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  bin2bcd_seq #(
    .W      (W),
    .DIGITS (DIGITS)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .bin_i   (bin),
    .busy_o  (busy),
    .done_o  (done),
    .bcd_o   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Decimal digits by plain division.
  function automatic logic [BW-1:0] to_bcd(input int unsigned v);
    logic [BW-1:0] r;
    int unsigned   t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
    end
  endtask

  // Reference: a conversion accepted while idle finishes W cycles later and frees the block one
  // cycle after that.
  bit            m_active = 1'b0;
  int            m_age    = 0;
  int unsigned   m_val    = 0;
  logic [BW-1:0] m_bcd    = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_age    <= 0;
      m_bcd    <= '0;
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1'b1;
        m_age    <= 0;
        m_val    <= int'(bin);
      end
    end else begin
      m_age <= m_age + 1;
      if (m_age + 1 == int'(W)) m_bcd <= to_bcd(m_val);
      if (m_age + 1 == int'(W) + 1) m_active <= 1'b0;
    end
  end

  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_active));
    check("done", 32'(done), 32'(m_active && m_age == int'(W)));
    check("bcd", 32'(bcd), 32'(m_bcd));
    if (done) begin
      for (int i = 0; i < DIGITS; i++) check("nibble<=9", 32'(bcd[4*i +: 4] <= 4'd9), 32'd1);
    end
  end

  task automatic wait_done(input int c0, input logic [BW-1:0] exp, input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < int'(W) + 4 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({name, " done seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({name, " latency"}, 32'(cyc - c0), W);
      check({name, " value"}, 32'(bcd), 32'(exp));
      @(negedge clk);
      check({name, " done width"}, 32'(done), 32'd0);
      check({name, " busy after"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic conv(input logic [W-1:0] v, input logic [BW-1:0] exp, input string name);
    int c0;
    @(negedge clk);
    #1 start = 1'b1;
    bin = v;
    @(negedge clk);
    c0 = cyc;
    #1 start = 1'b0;
    wait_done(c0, exp, name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  c0;
    int  c1;
    bit  extra;

    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    check("reset bcd", 32'(bcd), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    #1 rst_n = 1'b1;

    conv(16'd0, 20'h00000, "zero");
    conv(16'd1234, 20'h01234, "1234");
    conv(16'hFFFF, 20'h65535, "ffff");

    // Second request at edge 3 and edge W+1 must be ignored.
    @(negedge clk);
    #1 start = 1'b1;
    bin = 16'd42;
    @(negedge clk);
    c0 = cyc;
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    #1 start = 1'b1;
    bin = 16'd99;
    @(negedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < int'(W) + 4 && cyc < c0 + int'(W); k++) @(negedge clk);
    check("ignore done", 32'(done), 32'd1);
    check("ignore value", 32'(bcd), 32'h00042);
    #1 start = 1'b1;
    bin = 16'd99;
    @(negedge clk);
    #1 start = 1'b0;
    extra = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) extra = 1'b1;
    end
    check("ignore no 2nd done", 32'(extra), 32'd0);
    check("ignore held value", 32'(bcd), 32'h00042);

    // Asynchronous reset just after edge 5 of a conversion.
    @(negedge clk);
    #1 start = 1'b1;
    bin = 16'd9999;
    @(negedge clk);
    c0 = cyc;
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst bcd", 32'(bcd), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    conv(16'd7, 20'h00007, "after rst");

    // start held high: accepts at edge 0 and edge W+2.
    @(negedge clk);
    #1 start = 1'b1;
    bin = 16'd9;
    @(negedge clk);
    c0 = cyc;
    #1 bin = 16'd10;
    wait_done(c0, 20'h00009, "hold 1st");
    @(negedge clk);
    c1 = cyc;
    check("hold accept edge", 32'(c1 - c0), W + 2);
    #1 start = 1'b0;
    wait_done(c1, 20'h00010, "hold 2nd");

    // Spread of operands checked against the arithmetic model.
    for (int i = 0; i < 1500; i++) begin
      logic [W-1:0] v;
      v = W'(i * 43 + i / 7);
      conv(v, to_bcd(int'(v)), "sweep");
    end
    conv(16'd9999, 20'h09999, "9999");
    conv(16'd10000, 20'h10000, "10000");
    conv(16'd59999, 20'h59999, "59999");

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
